conv_frame_ctrl: RTL and testbench
==================================

// Module: conv_frame_ctrl
// PURPOSE
//   Frame sequencer for the rate-1/2, K=3 convolutional encoder datapath (g0=7, g1=5 octal).
//   Clears the encoder shift register and accepts data bits over a valid/ready handshake.
//   Appends TAIL_LEN zero flush bits, then emits shift strobes and symbol-phase selects.
//   Replaces the divided-clock scheme: single clock, strobes act as clock enables.
// PARAMETERS
//   FRAME_LEN_W  8  width of frame length / bit counter; max frame 2^FRAME_LEN_W-1 bits
//   TAIL_LEN     2  zero flush bits appended per frame (K-1)
// PORTS
//   clk        in   1            system clock, all logic on posedge
//   rst        in   1            synchronous reset, active high
//   start      in   1            frame start pulse; frame_len sampled on same edge
//   frame_len  in   FRAME_LEN_W  number of data bits in frame
//   in_valid   in   1            data bit valid
//   in_bit     in   1            data bit
//   in_ready   out  1            controller accepts in_bit this cycle
//   enc_clr    out  1            clear encoder shift register (1-cycle pulse)
//   enc_shift  out  1            shift enc_x into encoder (1-cycle pulse)
//   enc_x      out  1            bit to shift (data or tail zero)
//   enc_phase  out  1            symbol select: 0 = g0 (111), 1 = g1 (101)
//   out_valid  out  1            encoder output symbol valid this cycle
//   out_last   out  1            final emitted symbol of frame
//   busy       out  1            frame in progress
//   done       out  1            1-cycle pulse after out_last cycle
// BEHAVIOUR
//   Reset: state IDLE, counters 0; all outputs 0 on the edge after rst sampled high; applies mid-frame too (frame aborted, no done).
//   FSM: IDLE -> CLEAR -> DATA -> TAIL -> DONE -> IDLE. busy=1 in every state except IDLE.
//   IDLE: start && frame_len!=0 -> CLEAR, latch frame_len. start with frame_len==0 ignored. start ignored outside IDLE.
//   CLEAR: enc_clr=1 exactly one cycle; -> DATA, bit count 0, slot free.
//   Slot cadence: bit accepted in cycle t -> enc_shift=1, enc_x=bit in t+1 -> out_valid, enc_phase=0 in t+2 -> out_valid, enc_phase=1 in t+3.
//   DATA: in_ready=1 (combinational) when slot free, i.e. not in the cycle right after an accept. Earliest next accept t+2.
//     Back-to-back input gives one symbol per cycle. in_valid low keeps in_ready high; the output shows a bubble and stays out of order-free.
//   Last data bit accepted (count==frame_len) -> TAIL; in_ready=0 from that cycle on.
//   TAIL: controller self-issues TAIL_LEN zero bits on the same 2-cycle cadence with no stalls. First tail slot = t+2 of last data accept.
//   out_last=1 with the final emitted symbol; next cycle DONE: done=1, busy=1; then IDLE.
//   Symbols per frame = 2*(frame_len+TAIL_LEN) (no puncturing).
//   Counter: FRAME_LEN_W bits, compares to latched length, never wraps within a frame.
//   All outputs except in_ready are registered.
// CONFIGURATION
//   CONV_CTRL_PUNCTURE_EN defined: rate-2/3 puncturing. Bits are indexed 0..N-1 over data+tail, N=frame_len+TAIL_LEN.
//     For odd-indexed bits, out_valid=0 in the phase-1 cycle; enc_phase timing is unchanged.
//     Symbols = 2N - floor(N/2). If N is even, out_last sits on the phase-0 symbol of bit N-1 and done follows 2 cycles later, not 1.
//   Undefined: every phase-1 symbol valid, rate 1/2.
// TESTING
//   start at cyc0, frame_len=3, bits 1,0,1, in_valid held 1 -> enc_clr cyc1; accepts cyc2,4,6.
//     enc_shift cyc3,5,7,9,11 with enc_x 1,0,1,0,0; out_valid cyc4..13; out_last cyc13; done cyc14.
//   Same stimulus plus reference (7,5) encoder model on strobes -> symbol stream 11 10 00 10 11.
//   in_valid low for 3 cycles before bit 2 -> in_ready held high; shifts delayed 3 cycles; symbol count still 10.
//   rst high at cyc5 of the first scenario -> all outputs 0 at cyc6, state IDLE, no done; new start then runs cleanly.
//   start with frame_len=0, and start while busy -> ignored: no enc_clr, busy unchanged.
//   PUNCTURE_EN, frame_len=3 (N=5) -> 8 valid symbols; phase-1 of bits 1,3 suppressed; out_last cyc13.

Source files
------------

// File: rtl/conv_frame_ctrl.sv
// Frame sequencer for the rate-1/2 K=3 (7,5) convolutional encoder: clear, data, zero tail, done.
// Optional rate-2/3 puncturing of odd-indexed bits when CONV_CTRL_PUNCTURE_EN is defined.
module conv_frame_ctrl #(
    parameter int unsigned FRAME_LEN_W = 8,
    parameter int unsigned TAIL_LEN    = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [FRAME_LEN_W-1:0] frame_len,
    input  logic                   in_valid,
    input  logic                   in_bit,
    output logic                   in_ready,
    output logic                   enc_clr,
    output logic                   enc_shift,
    output logic                   enc_x,
    output logic                   enc_phase,
    output logic                   out_valid,
    output logic                   out_last,
    output logic                   busy,
    output logic                   done
);

`ifdef CONV_CTRL_PUNCTURE_EN
    localparam logic PUNCT = 1'b1;
`else
    localparam logic PUNCT = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_DATA  = 3'd2,
        S_TAIL  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                 state, state_d;
    logic [FRAME_LEN_W-1:0] len_q, len_d;
    logic [FRAME_LEN_W-1:0] cnt, cnt_d;
    logic                   odd, odd_d;

    // Per-bit pipeline tags: l* = final bit of frame, o* = odd bit index.
    logic ph0, ph0_d;
    logic l1, l2, l3, l1_d, l2_d, l3_d;
    logic o1, o2, o1_d, o2_d;

    logic enc_clr_d, enc_shift_d, enc_x_d, enc_phase_d;
    logic out_valid_d, out_last_d, busy_d, done_d;
    logic issue, issue_x, issue_last;

    // A slot is occupied for the cycle right after any issued bit.
    assign in_ready = (state == S_DATA) && !enc_shift;

    always_comb begin
        state_d     = state;
        len_d       = len_q;
        cnt_d       = cnt;
        odd_d       = odd;
        issue       = 1'b0;
        issue_x     = 1'b0;
        issue_last  = 1'b0;

        case (state)
            S_IDLE: begin
                if (start && (frame_len != '0)) begin
                    state_d = S_CLEAR;
                    len_d   = frame_len;
                end
            end
            S_CLEAR: begin
                state_d = S_DATA;
                cnt_d   = '0;
                odd_d   = 1'b0;
            end
            S_DATA: begin
                if (in_valid && !enc_shift) begin
                    issue   = 1'b1;
                    issue_x = in_bit;
                    cnt_d   = cnt + FRAME_LEN_W'(1);
                    if ((cnt + FRAME_LEN_W'(1)) == len_q) begin
                        state_d = S_TAIL;
                        cnt_d   = '0;
                    end
                end
            end
            S_TAIL: begin
                if (!enc_shift && (cnt < FRAME_LEN_W'(TAIL_LEN))) begin
                    issue      = 1'b1;
                    cnt_d      = cnt + FRAME_LEN_W'(1);
                    issue_last = (cnt == FRAME_LEN_W'(TAIL_LEN - 1));
                end
                // Leave once the final bit has passed its phase-1 slot.
                if (enc_phase && l3) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (issue) begin
            odd_d = ~odd;
        end

        enc_shift_d = issue;
        enc_x_d     = issue_x;
        l1_d        = issue_last;
        o1_d        = issue & odd;
        ph0_d       = enc_shift;
        l2_d        = l1;
        o2_d        = o1;
        enc_phase_d = ph0;
        l3_d        = l2;
        out_valid_d = enc_shift | (ph0 & !(PUNCT & o2));
        out_last_d  = (ph0 & l2 & !(PUNCT & o2)) | (PUNCT & enc_shift & l1 & o1);
        busy_d      = (state_d != S_IDLE);
        enc_clr_d   = (state_d == S_CLEAR);
        done_d      = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            len_q     <= '0;
            cnt       <= '0;
            odd       <= 1'b0;
            ph0       <= 1'b0;
            l1        <= 1'b0;
            l2        <= 1'b0;
            l3        <= 1'b0;
            o1        <= 1'b0;
            o2        <= 1'b0;
            enc_clr   <= 1'b0;
            enc_shift <= 1'b0;
            enc_x     <= 1'b0;
            enc_phase <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_d;
            len_q     <= len_d;
            cnt       <= cnt_d;
            odd       <= odd_d;
            ph0       <= ph0_d;
            l1        <= l1_d;
            l2        <= l2_d;
            l3        <= l3_d;
            o1        <= o1_d;
            o2        <= o2_d;
            enc_clr   <= enc_clr_d;
            enc_shift <= enc_shift_d;
            enc_x     <= enc_x_d;
            enc_phase <= enc_phase_d;
            out_valid <= out_valid_d;
            out_last  <= out_last_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

endmodule

// File: tb/tb_conv_frame_ctrl.sv
// Self-checking bench for conv_frame_ctrl: directed timing scenarios plus randomized frames
// compared against an arithmetic (7,5) encoder reference.
module tb_conv_frame_ctrl;

    localparam int unsigned FLW  = 8;
    localparam int          TAIL = 2;
`ifdef CONV_CTRL_PUNCTURE_EN
    localparam bit PUNCT = 1'b1;
`else
    localparam bit PUNCT = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst, start, in_valid, in_bit;
    logic [FLW-1:0] frame_len;
    logic           in_ready, enc_clr, enc_shift, enc_x, enc_phase;
    logic           out_valid, out_last, busy, done;

    conv_frame_ctrl #(.FRAME_LEN_W(FLW), .TAIL_LEN(TAIL)) dut (
        .clk(clk), .rst(rst), .start(start), .frame_len(frame_len),
        .in_valid(in_valid), .in_bit(in_bit), .in_ready(in_ready),
        .enc_clr(enc_clr), .enc_shift(enc_shift), .enc_x(enc_x),
        .enc_phase(enc_phase), .out_valid(out_valid), .out_last(out_last),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [255:0] data_v;
    logic [511:0] ready_hist;
    logic [8:0]   rst_snap;
    int clr_q[$], acc_q[$], sh_q[$], val_q[$], last_q[$], done_q[$];
    bit shx_q[$], sym_q[$], exp_sym[$], exp_bits[$];
    int busy_n, rdy_err;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: plain (7,5) encoding of data followed by zero tail, with optional puncturing.
    function automatic void build_exp(input int len);
        int n;
        bit b, d1, d2;
        exp_sym.delete();
        exp_bits.delete();
        n = len + TAIL;
        for (int i = 0; i < n; i++) exp_bits.push_back((i < len) ? data_v[i] : 1'b0);
        for (int i = 0; i < n; i++) begin
            b  = exp_bits[i];
            d1 = (i >= 1) ? exp_bits[i-1] : 1'b0;
            d2 = (i >= 2) ? exp_bits[i-2] : 1'b0;
            exp_sym.push_back(b ^ d1 ^ d2);
            if (!(PUNCT && (i % 2 == 1))) exp_sym.push_back(b ^ d2);
        end
    endfunction

    // vmode: 0 = in_valid always 1, 1 = random, 2 = low during cycles 6..8.
    task automatic run_frame(input int len, input int vmode, input int rst_at,
                             input int restart_at, input int ncyc);
        logic [2:0] win;
        int  next_bit;
        bit  prev_acc;
        clr_q.delete(); acc_q.delete(); sh_q.delete(); val_q.delete();
        last_q.delete(); done_q.delete(); shx_q.delete(); sym_q.delete();
        busy_n = 0; rdy_err = 0; next_bit = 0; prev_acc = 1'b0;
        win = 3'b000; ready_hist = '0; rst_snap = '1;
        for (int k = 0; k < ncyc; k++) begin
            @(posedge clk);
            #1;
            start     = (k == 0) || (k == restart_at);
            frame_len = (k == restart_at) ? FLW'(9) : FLW'(len);
            rst       = (k == rst_at);
            case (vmode)
                0:       in_valid = 1'b1;
                1:       in_valid = ($urandom % 3) != 0;
                default: in_valid = !(k >= 6 && k <= 8);
            endcase
            in_bit = (next_bit < 256) ? data_v[next_bit] : 1'b0;
            if (k == rst_at + 1)
                rst_snap = {in_ready, enc_clr, enc_shift, enc_x, enc_phase,
                            out_valid, out_last, busy, done};
            if (enc_clr) clr_q.push_back(k);
            if (out_valid) begin
                val_q.push_back(k);
                sym_q.push_back(enc_phase ? (win[2] ^ win[0]) : (^win));
            end
            if (enc_shift) begin
                sh_q.push_back(k);
                shx_q.push_back(enc_x);
                win = {enc_x, win[2:1]};
            end
            if (enc_clr) win = 3'b000;
            if (out_last) last_q.push_back(k);
            if (done) done_q.push_back(k);
            if (busy) busy_n++;
            if (in_ready && prev_acc) rdy_err++;
            ready_hist[k] = in_ready;
            prev_acc = in_ready && in_valid;
            if (prev_acc) begin
                acc_q.push_back(k);
                next_bit++;
            end
        end
        @(posedge clk);
        #1;
        start = 1'b0; in_valid = 1'b0; rst = 1'b0;
    endtask

    // Generic frame checks derived from the expected bit sequence and cadence rules.
    task automatic check_frame(input string nm, input int len);
        int n, err, lastsh, exp_last, exp_done;
        n = len + TAIL;
        build_exp(len);
        chk({nm, ".clr_count"}, clr_q.size(), 1);
        if (clr_q.size() > 0) chk({nm, ".clr_cyc"}, clr_q[0], 1);
        chk({nm, ".acc_count"}, acc_q.size(), len);
        chk({nm, ".shift_count"}, sh_q.size(), n);
        err = 0;
        for (int i = 0; i < sh_q.size() && i < n; i++) begin
            if (shx_q[i] !== exp_bits[i]) err++;
            if (i < len && i < acc_q.size() && sh_q[i] != acc_q[i] + 1) err++;
            if (i >= len && sh_q[i] != sh_q[i-1] + 2) err++;
        end
        chk({nm, ".shift_x_cadence_err"}, err, 0);
        chk({nm, ".in_ready_slot_err"}, rdy_err, 0);
        chk({nm, ".sym_count"}, sym_q.size(), exp_sym.size());
        err = 0;
        for (int i = 0; i < sym_q.size() && i < exp_sym.size(); i++)
            if (sym_q[i] !== exp_sym[i]) err++;
        chk({nm, ".sym_err"}, err, 0);
        lastsh   = (sh_q.size() > 0) ? sh_q[sh_q.size()-1] : -100;
        exp_last = lastsh + ((PUNCT && ((n - 1) % 2 == 1)) ? 1 : 2);
        exp_done = lastsh + 3;
        chk({nm, ".last_count"}, last_q.size(), 1);
        if (last_q.size() > 0) chk({nm, ".last_cyc"}, last_q[0], exp_last);
        if (val_q.size() > 0) chk({nm, ".last_valid_cyc"}, val_q[val_q.size()-1], exp_last);
        chk({nm, ".done_count"}, done_q.size(), 1);
        if (done_q.size() > 0) chk({nm, ".done_cyc"}, done_q[0], exp_done);
        chk({nm, ".busy_cycles"}, busy_n, exp_done);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_bit = 1'b0; frame_len = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", int'({in_ready, enc_clr, enc_shift, enc_x, enc_phase,
                                   out_valid, out_last, busy, done}), 0);
        rst = 1'b0;

        // Directed frame: bits 1,0,1 with continuous valid.
        data_v = '0;
        data_v[2:0] = 3'b101;
        run_frame(3, 0, -1, -1, 20);
        check_frame("dir3", 3);
        if (acc_q.size() == 3) begin
            chk("dir3.acc1", acc_q[1], 4);
            chk("dir3.acc2", acc_q[2], 6);
        end
        if (sh_q.size() == 5) chk("dir3.tail_shift_last", sh_q[4], 11);
        if (val_q.size() > 0) chk("dir3.first_valid", val_q[0], 4);
        if (last_q.size() > 0) chk("dir3.out_last", last_q[0], 13);
        if (done_q.size() > 0) chk("dir3.done", done_q[0], 14);
        chk("dir3.sym_total", sym_q.size(), PUNCT ? 8 : 10);

        // Valid bubble before the third bit.
        run_frame(3, 2, -1, -1, 24);
        check_frame("gap3", 3);
        if (acc_q.size() == 3) chk("gap3.acc2", acc_q[2], 9);
        chk("gap3.ready_held", int'(ready_hist[8:6]), 7);

        // Mid-frame reset.
        run_frame(3, 0, 5, -1, 18);
        chk("abort.outputs_zero", int'(rst_snap), 0);
        chk("abort.no_done", done_q.size(), 0);
        chk("abort.no_last", last_q.size(), 0);
        data_v[2:0] = 3'b011;
        run_frame(3, 0, -1, -1, 20);
        check_frame("after_abort", 3);

        // Zero-length start is ignored.
        run_frame(0, 0, -1, -1, 8);
        chk("len0.no_clr", clr_q.size(), 0);
        chk("len0.not_busy", busy_n, 0);

        // Start while busy is ignored.
        data_v[2:0] = 3'b110;
        run_frame(3, 0, -1, 3, 20);
        check_frame("restart", 3);

        // Randomized frames.
        for (int f = 0; f < 8; f++) begin
            int len;
            len = $urandom_range(1, 12);
            for (int w = 0; w < 8; w++) data_v[w*32 +: 32] = $urandom;
            run_frame(len, 1, -1, -1, 6 * len + 30);
            check_frame($sformatf("rand%0d_len%0d", f, len), len);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
